mem_request_unit: RTL and testbench
===================================

Name: mem_request_unit

Overview:
Bus-side request sequencer between the CPU core and the single-port memory bus. Accepts instruction-fetch and data load/store requests from the core and serializes them onto the bus (address_out, data_out_BUS, strobes). Waits for the bus completion strobe bus_full, then returns captured data to the core with a one-cycle valid pulse. Drives the core's instr_wait stall while a bus transaction is outstanding.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; byte-select width is DATA_W/8.
TIMEOUT_CYCLES, 16, wait-state limit, used only with MEM_REQ_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
fetch_req  in  1  instruction fetch request; level, held until instr_valid.
fetch_addr  in  ADDR_W  fetch address (PC).
dmem_read  in  1  load request; level, held until dmem_valid.
dmem_write  in  1  store request; level, held until dmem_valid.
dmem_addr  in  ADDR_W  load/store address.
dmem_wdata  in  DATA_W  store data.
dmem_sel  in  DATA_W/8  store byte enables.
instr_out  out  DATA_W  last fetched instruction.
instr_valid  out  1  one-cycle fetch-complete pulse.
dmem_rdata  out  DATA_W  last loaded data word.
dmem_valid  out  1  one-cycle load/store-complete pulse.
instr_wait  out  1  core stall; high while a bus transaction is outstanding.
bus_read  out  1  bus read strobe.
bus_write  out  1  bus write strobe.
address_out  out  ADDR_W  bus address.
data_out_BUS  out  DATA_W  bus write data.
bus_sel  out  DATA_W/8  bus byte enables.
data_in_BUS  in  DATA_W  bus read data; valid when bus_full=1.
bus_full  in  1  bus completion strobe.
timeout_err  out  1  one-cycle timeout pulse.

Behaviour:
- States: IDLE, FETCH, LOAD, STORE, RESP. All outputs are registered.
- Reset: state=IDLE and every output is 0, including instr_out and dmem_rdata.
- rst asserted mid-transaction aborts the transaction: outputs go to 0 at the next edge and no valid pulse is issued.
- IDLE accept priority: dmem_write > dmem_read > fetch_req.
  - dmem_read and dmem_write both high: the store is served; the read is not queued. The core re-presents it.
- On accept, the unit latches the address, wdata and sel. Next state is FETCH, LOAD or STORE.
  - bus_read or bus_write, address_out, data_out_BUS and bus_sel become valid after the accepting edge.
  - instr_wait rises at the same edge.
- Fetch address: address_out[1:0] is forced to 0. Data addresses pass through unchanged.
- FETCH: bus_sel=all ones, data_out_BUS=0.
- LOAD: bus_sel=all ones.
- STORE: bus_sel=dmem_sel. dmem_sel=0 is still issued to the bus.
- Wait states: bus outputs are held stable until bus_full is sampled at 1.
  - On completion, FETCH captures data_in_BUS into instr_out; LOAD captures it into dmem_rdata; STORE captures nothing.
  - Then: strobes drop to 0, instr_wait drops to 0, and the state goes to RESP.
- RESP lasts exactly one cycle.
  - instr_valid (FETCH) or dmem_valid (LOAD/STORE) is 1 during RESP.
  - New requests are ignored in RESP. Next state is IDLE.
- Minimum latency: request sampled at edge N → strobe high after N → bus_full sampled at N+1 → valid high after N+1 → IDLE after N+2. The next accept is at the earliest at edge N+3.
- bus_full is ignored in IDLE and RESP.
- instr_out and dmem_rdata hold their values until the next capture.

Optional Feature:
MEM_REQ_TIMEOUT_EN:
- Defined: a wait counter resets on each accept and increments each cycle in FETCH, LOAD or STORE.
  - When it reaches TIMEOUT_CYCLES without bus_full, the unit drops the strobes and enters RESP.
  - In that RESP cycle, timeout_err=1 alongside the normal valid pulse.
  - Read data on timeout: instr_out or dmem_rdata is loaded with 32'hBAD0_0BAD.
  - bus_full in the same cycle as the limit wins over the timeout: normal completion, no error.
- Undefined: the unit waits indefinitely, timeout_err is tied to 0, and there is no counter logic.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs → every output is 0 and state=IDLE. After release with no requests, bus strobes stay 0.
2. Fetch: fetch_addr=0x0000_0106; bus_full asserted after 3 wait cycles with data_in_BUS=0x0031_00B3.
   - address_out=0x0000_0104; bus_read high for exactly 3 cycles then the completion cycle.
   - instr_out=0x0031_00B3; instr_valid high for exactly 1 cycle; instr_wait=1 throughout the wait.
3. Load: dmem_read, dmem_addr=0x24, bus_full with data_in_BUS=0xFFFF_0000 → dmem_rdata=0xFFFF_0000, dmem_valid pulse; instr_out unchanged.
4. Contention: fetch_req and dmem_write (addr 0x40, wdata 0x0000_FFFF, sel 0xF) in the same cycle.
   - Store first: bus_write=1, data_out_BUS=0x0000_FFFF, bus_sel=0xF; then dmem_valid.
   - The fetch is accepted at the first IDLE edge after RESP.
5. Reset mid-LOAD: rst=1 while bus_read=1, bus_full=1 in the same cycle → no dmem_valid, dmem_rdata=0, state=IDLE.
6. Timeout (MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): load with no bus_full.
   - After 16 wait cycles: timeout_err=1 and dmem_valid=1 for one cycle; dmem_rdata=0xBAD0_0BAD.
   - Without the macro: bus_read stays high for 100+ cycles and timeout_err=0.

Source files
------------

// File: rtl/mem_request_unit_if.sv
// mem_request_unit_if: every signal between the request sequencer, the core
// and the single-port memory bus.
//   slave  : the mem_request_unit itself (takes core requests and bus
//            completions, drives the responses and the bus strobes).
//   master : the environment around it (core plus memory), which drives the
//            requests and the bus completion.
// Handshake rules:
//   - Core requests (fetch_req, dmem_read, dmem_write) are levels.
//     The core holds each one until the matching one-cycle valid pulse.
//   - Bus strobes (bus_read, bus_write) stay high with address_out,
//     data_out_BUS and bus_sel stable until bus_full is sampled high on a
//     rising edge. data_in_BUS is meaningful only in that cycle.
interface mem_request_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core side
    logic                  fetch_req;
    logic [ADDR_W-1:0]     fetch_addr;
    logic                  dmem_read;
    logic                  dmem_write;
    logic [ADDR_W-1:0]     dmem_addr;
    logic [DATA_W-1:0]     dmem_wdata;
    logic [DATA_W/8-1:0]   dmem_sel;
    logic [DATA_W-1:0]     instr_out;
    logic                  instr_valid;
    logic [DATA_W-1:0]     dmem_rdata;
    logic                  dmem_valid;
    logic                  instr_wait;
    // Bus side
    logic                  bus_read;
    logic                  bus_write;
    logic [ADDR_W-1:0]     address_out;
    logic [DATA_W-1:0]     data_out_BUS;
    logic [DATA_W/8-1:0]   bus_sel;
    logic [DATA_W-1:0]     data_in_BUS;
    logic                  bus_full;
    // Status
    logic                  timeout_err;

    modport slave (
        input  fetch_req, fetch_addr, dmem_read, dmem_write, dmem_addr,
               dmem_wdata, dmem_sel, data_in_BUS, bus_full,
        output instr_out, instr_valid, dmem_rdata, dmem_valid, instr_wait,
               bus_read, bus_write, address_out, data_out_BUS, bus_sel,
               timeout_err
    );

    modport master (
        output fetch_req, fetch_addr, dmem_read, dmem_write, dmem_addr,
               dmem_wdata, dmem_sel, data_in_BUS, bus_full,
        input  instr_out, instr_valid, dmem_rdata, dmem_valid, instr_wait,
               bus_read, bus_write, address_out, data_out_BUS, bus_sel,
               timeout_err
    );
endinterface

// File: rtl/mem_request_unit.sv
// mem_request_unit: serializes instruction fetches and data loads/stores
// from the core onto a single-port memory bus, one transaction at a time.
//
// Flow: IDLE accepts one request (store > load > fetch). The unit then sits
// in FETCH/LOAD/STORE with the bus strobe held until bus_full. It spends one
// RESP cycle pulsing the valid for the served request, then returns to IDLE.
// Every output comes straight from a flop.
//
// Optional build macro: MEM_REQ_TIMEOUT_EN
//   When defined, a transaction that sees no bus_full for TIMEOUT_CYCLES
//   wait cycles is abandoned. It completes with timeout_err and, for reads,
//   the marker word 32'hBAD0_0BAD. When undefined, the unit waits forever
//   and timeout_err is tied low.
//
// state_dbg encoding: 0 IDLE, 1 FETCH, 2 LOAD, 3 STORE, 4 RESP.
module mem_request_unit #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_request_unit_if.slave mif,
    output logic [2:0]        state_dbg
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_STORE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;

    logic [DATA_W-1:0]   instr_out_q,   instr_out_d;
    logic [DATA_W-1:0]   dmem_rdata_q,  dmem_rdata_d;
    logic                instr_valid_q, instr_valid_d;
    logic                dmem_valid_q,  dmem_valid_d;
    logic                instr_wait_q,  instr_wait_d;
    logic                bus_read_q,    bus_read_d;
    logic                bus_write_q,   bus_write_d;
    logic [ADDR_W-1:0]   address_q,     address_d;
    logic [DATA_W-1:0]   wdata_q,       wdata_d;
    logic [SEL_W-1:0]    sel_q,         sel_d;

    // Completion of the current bus transaction in this cycle, and the word
    // to capture for reads (bus data, or the timeout marker).
    logic                complete;
    logic [DATA_W-1:0]   capture;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hBAD0_0BAD);

    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic                timeout_hit;

    // This wait edge would be the TIMEOUT_CYCLES-th without a completion.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // The wait limit only matters when the timeout logic is built in.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

    // Next-state and next-output logic; every *_d defaults to holding.
    always_comb begin
        state_d       = state_q;
        instr_out_d   = instr_out_q;
        dmem_rdata_d  = dmem_rdata_q;
        instr_valid_d = 1'b0;
        dmem_valid_d  = 1'b0;
        instr_wait_d  = instr_wait_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        address_d     = address_q;
        wdata_d       = wdata_q;
        sel_d         = sel_q;
        complete      = 1'b0;
        capture       = mif.data_in_BUS;
`ifdef MEM_REQ_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                // A simultaneous load is dropped, not queued; the core
                // keeps its request up and it is taken on a later pass.
                if (mif.dmem_write) begin
                    state_d      = S_STORE;
                    bus_write_d  = 1'b1;
                    address_d    = mif.dmem_addr;
                    wdata_d      = mif.dmem_wdata;
                    sel_d        = mif.dmem_sel;
                    instr_wait_d = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end else if (mif.dmem_read) begin
                    state_d      = S_LOAD;
                    bus_read_d   = 1'b1;
                    address_d    = mif.dmem_addr;
                    wdata_d      = '0;
                    sel_d        = '1;
                    instr_wait_d = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end else if (mif.fetch_req) begin
                    // Instruction fetches are always word aligned on the bus.
                    state_d      = S_FETCH;
                    bus_read_d   = 1'b1;
                    address_d    = mif.fetch_addr & ~ADDR_W'(3);
                    wdata_d      = '0;
                    sel_d        = '1;
                    instr_wait_d = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end
            end

            S_FETCH, S_LOAD, S_STORE: begin
                // bus_full on the limit cycle still counts as a completion.
                if (mif.bus_full) begin
                    complete = 1'b1;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    complete      = 1'b1;
                    capture       = TIMEOUT_DATA;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif

                if (complete) begin
                    if (state_q == S_FETCH) begin
                        instr_out_d = capture;
                    end
                    if (state_q == S_LOAD) begin
                        dmem_rdata_d = capture;
                    end
                    instr_valid_d = (state_q == S_FETCH);
                    dmem_valid_d  = (state_q != S_FETCH);
                    // Release the bus completely; address/data/sel are
                    // parked at 0 while no strobe is up.
                    bus_read_d    = 1'b0;
                    bus_write_d   = 1'b0;
                    address_d     = '0;
                    wdata_d       = '0;
                    sel_d         = '0;
                    instr_wait_d  = 1'b0;
                    state_d       = S_RESP;
                end
            end

            // One response cycle; requests presented now are not looked at.
            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, aborting any
    // transaction in flight without a valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_out_q   <= '0;
            dmem_rdata_q  <= '0;
            instr_valid_q <= 1'b0;
            dmem_valid_q  <= 1'b0;
            instr_wait_q  <= 1'b0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
            address_q     <= '0;
            wdata_q       <= '0;
            sel_q         <= '0;
        end else begin
            state_q       <= state_d;
            instr_out_q   <= instr_out_d;
            dmem_rdata_q  <= dmem_rdata_d;
            instr_valid_q <= instr_valid_d;
            dmem_valid_q  <= dmem_valid_d;
            instr_wait_q  <= instr_wait_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
            address_q     <= address_d;
            wdata_q       <= wdata_d;
            sel_q         <= sel_d;
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    // Wait-cycle counter and the registered timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mif.timeout_err = timeout_err_q;
`else
    assign mif.timeout_err = 1'b0;
`endif

    assign mif.instr_out    = instr_out_q;
    assign mif.instr_valid  = instr_valid_q;
    assign mif.dmem_rdata   = dmem_rdata_q;
    assign mif.dmem_valid   = dmem_valid_q;
    assign mif.instr_wait   = instr_wait_q;
    assign mif.bus_read     = bus_read_q;
    assign mif.bus_write    = bus_write_q;
    assign mif.address_out  = address_q;
    assign mif.data_out_BUS = wdata_q;
    assign mif.bus_sel      = sel_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed test of mem_request_unit. A transaction-level
// reference model runs beside the DUT and is compared every cycle. Directed
// literal checks pin the reset, fetch, load, contention, reset-abort and
// wait-limit cases.
module tb_mem_request_unit;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int K_FETCH        = 0;
    localparam int K_LOAD         = 1;
    localparam int K_STORE        = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    mem_request_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    mem_request_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .mif(mif), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // busy: a bus transaction is outstanding; resp: the one-cycle response.
    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_resp = 0;
    bit          m_terr = 0;
    int          m_kind = 0;
    int          m_waited = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_rdata = '0;

    task automatic model_done(input logic [31:0] word, input bit terr);
        if (m_kind == K_FETCH) m_instr = word;
        if (m_kind == K_LOAD)  m_rdata = word;
        m_busy = 0;
        m_resp = 1;
        m_terr = terr;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1;
            m_busy  = 0;
            m_resp  = 0;
            m_terr  = 0;
            m_instr = '0;
            m_rdata = '0;
        end else if (m_resp) begin
            m_resp = 0;
            m_terr = 0;
        end else if (m_busy) begin
            m_waited++;
            if (mif.bus_full) model_done(mif.data_in_BUS, 0);
`ifdef MEM_REQ_TIMEOUT_EN
            else if (m_waited == TIMEOUT_CYCLES) model_done(32'hBAD0_0BAD, 1);
`endif
        end else begin
            m_waited = 0;
            if (mif.dmem_write) begin
                m_busy = 1; m_kind = K_STORE;
                m_addr = mif.dmem_addr; m_wdata = mif.dmem_wdata; m_sel = mif.dmem_sel;
            end else if (mif.dmem_read) begin
                m_busy = 1; m_kind = K_LOAD;
                m_addr = mif.dmem_addr; m_wdata = '0; m_sel = 4'hF;
            end else if (mif.fetch_req) begin
                m_busy = 1; m_kind = K_FETCH;
                m_addr = {mif.fetch_addr[31:2], 2'b00}; m_wdata = '0; m_sel = 4'hF;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("bus_read",    mif.bus_read,    m_busy && m_kind != K_STORE);
            check("bus_write",   mif.bus_write,   m_busy && m_kind == K_STORE);
            check("instr_wait",  mif.instr_wait,  m_busy);
            check("instr_valid", mif.instr_valid, m_resp && m_kind == K_FETCH);
            check("dmem_valid",  mif.dmem_valid,  m_resp && m_kind != K_FETCH);
            check("timeout_err", mif.timeout_err, m_resp && m_terr);
            check("instr_out",   mif.instr_out,   m_instr);
            check("dmem_rdata",  mif.dmem_rdata,  m_rdata);
            check("state_idle",  state_dbg == 3'd0, !m_busy && !m_resp);
            if (m_busy) begin
                check("address_out", mif.address_out, m_addr);
                check("bus_sel",     mif.bus_sel,     m_sel);
                if (m_kind != K_LOAD) check("data_out_BUS", mif.data_out_BUS, m_wdata);
            end
        end
    end

    // Event counters used by the directed literal checks.
    int rd_hi = 0, wr_hi = 0, iv_cnt = 0, dv_cnt = 0, te_cnt = 0;
    always @(negedge clk) begin
        if (mif.bus_read    === 1'b1) rd_hi++;
        if (mif.bus_write   === 1'b1) wr_hi++;
        if (mif.instr_valid === 1'b1) iv_cnt++;
        if (mif.dmem_valid  === 1'b1) dv_cnt++;
        if (mif.timeout_err === 1'b1) te_cnt++;
    end

    task automatic clr_counts();
        rd_hi = 0; wr_hi = 0; iv_cnt = 0; dv_cnt = 0; te_cnt = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        mif.fetch_req  = 1'b0; mif.fetch_addr = '0;
        mif.dmem_read  = 1'b0; mif.dmem_write = 1'b0;
        mif.dmem_addr  = '0;   mif.dmem_wdata = '0; mif.dmem_sel = '0;
        mif.bus_full   = 1'b0; mif.data_in_BUS = $urandom;
    endtask

    // Memory responder: once a strobe is up, hold off for `waits` cycles,
    // then present bus_full with `rd` for a single edge.
    task automatic serve(input int waits, input logic [31:0] rd);
        int t = 0;
        while (!(mif.bus_read === 1'b1 || mif.bus_write === 1'b1) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL serve_strobe: got no strobe expected strobe within 50 cycles at %0t", $time);
        end
        repeat (waits) tick();
        mif.bus_full = 1'b1; mif.data_in_BUS = rd;
        tick();
        mif.bus_full = 1'b0; mif.data_in_BUS = $urandom;
    endtask

    // Directed loads: address, wait cycles, returned word.
    logic [31:0] ld_addr [3] = '{32'h0000_0001, 32'h0000_1002, 32'hFFFF_FFFF};
    int          ld_wait [3] = '{0, 2, 5};
    logic [31:0] ld_data [3] = '{32'h1234_5678, 32'h8000_0001, 32'hDEAD_BEEF};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle_inputs();

        // Reset with random inputs on the bus and core sides.
        tick();
        repeat (2) begin
            mif.fetch_req = 1'b1; mif.fetch_addr = $urandom;
            mif.dmem_read = 1'(($urandom)); mif.dmem_write = 1'(($urandom));
            mif.dmem_addr = $urandom; mif.dmem_wdata = $urandom; mif.dmem_sel = 4'($urandom);
            mif.bus_full = 1'(($urandom)); mif.data_in_BUS = $urandom;
            tick();
        end
        check("rst_state",    state_dbg, 3'd0);
        check("rst_outs",     {mif.instr_valid, mif.dmem_valid, mif.instr_wait,
                               mif.bus_read, mif.bus_write, mif.timeout_err}, 6'b0);
        check("rst_instr",    mif.instr_out, 32'h0);
        check("rst_rdata",    mif.dmem_rdata, 32'h0);
        check("rst_bus",      {mif.address_out, mif.data_out_BUS, mif.bus_sel}, 68'h0);
        idle_inputs();
        rst = 1'b0;
        clr_counts();
        repeat (4) tick();
        check("idle_strobes", rd_hi + wr_hi, 0);

        // Fetch, unaligned PC, three wait cycles.
        clr_counts();
        mif.fetch_req = 1'b1; mif.fetch_addr = 32'h0000_0106;
        tick();
        check("fetch_addr_out", mif.address_out, 32'h0000_0104);
        check("fetch_sel",      mif.bus_sel, 4'hF);
        serve(3, 32'h0031_00B3);
        mif.fetch_req = 1'b0;
        check("fetch_valid_now", mif.instr_valid, 1'b1);
        tick(); tick();
        check("fetch_rd_cycles", rd_hi, 4);
        check("fetch_valid_cnt", iv_cnt, 1);
        check("fetch_instr",     mif.instr_out, 32'h0031_00B3);

        // Load; instruction register must be left alone.
        clr_counts();
        mif.dmem_read = 1'b1; mif.dmem_addr = 32'h0000_0024;
        serve(0, 32'hFFFF_0000);
        mif.dmem_read = 1'b0;
        check("load_valid_now", mif.dmem_valid, 1'b1);
        tick(); tick();
        check("load_rdata",     mif.dmem_rdata, 32'hFFFF_0000);
        check("load_instr",     mif.instr_out, 32'h0031_00B3);
        check("load_valid_cnt", dv_cnt, 1);

        // Contention: store wins, fetch follows at the first IDLE edge.
        clr_counts();
        mif.fetch_req = 1'b1; mif.fetch_addr = 32'h0000_0200;
        mif.dmem_write = 1'b1; mif.dmem_addr = 32'h0000_0040;
        mif.dmem_wdata = 32'h0000_FFFF; mif.dmem_sel = 4'hF;
        tick();
        check("cont_store_first", {mif.bus_write, mif.bus_read}, 2'b10);
        check("cont_store_data",  mif.data_out_BUS, 32'h0000_FFFF);
        check("cont_store_sel",   mif.bus_sel, 4'hF);
        serve(1, $urandom);
        mif.dmem_write = 1'b0;
        check("cont_store_valid", mif.dmem_valid, 1'b1);
        tick();
        check("cont_resp_noread", mif.bus_read, 1'b0);
        tick();
        check("cont_fetch_start", mif.bus_read, 1'b1);
        check("cont_fetch_addr",  mif.address_out, 32'h0000_0200);
        serve(0, 32'h0000_0013);
        mif.fetch_req = 1'b0;
        tick(); tick();
        check("cont_instr", mif.instr_out, 32'h0000_0013);

        // Store with no byte enables still reaches the bus, address unchanged.
        mif.dmem_write = 1'b1; mif.dmem_addr = 32'h0000_1003;
        mif.dmem_wdata = 32'hA5A5_5A5A; mif.dmem_sel = 4'h0;
        mif.dmem_read = 1'b1;
        tick();
        check("sel0_write", mif.bus_write, 1'b1);
        check("sel0_addr",  mif.address_out, 32'h0000_1003);
        check("sel0_sel",   mif.bus_sel, 4'h0);
        serve(2, $urandom);
        mif.dmem_write = 1'b0; mif.dmem_read = 1'b0;
        tick(); tick();

        // Directed load table with varying wait states.
        for (int i = 0; i < 3; i++) begin
            mif.dmem_read = 1'b1; mif.dmem_addr = ld_addr[i];
            serve(ld_wait[i], ld_data[i]);
            mif.dmem_read = 1'b0;
            tick(); tick();
        end
        check("tbl_last_rdata", mif.dmem_rdata, 32'hDEAD_BEEF);

        // Fetch at the top of the address space is aligned down.
        mif.fetch_req = 1'b1; mif.fetch_addr = 32'hFFFF_FFFF;
        tick();
        check("fetch_top_addr", mif.address_out, 32'hFFFF_FFFC);
        serve(1, 32'h0000_0073);
        mif.fetch_req = 1'b0;
        tick(); tick();

        // Reset in the same cycle as the load completion: no response.
        clr_counts();
        mif.dmem_read = 1'b1; mif.dmem_addr = 32'h0000_0080;
        tick();
        check("abort_started", mif.bus_read, 1'b1);
        mif.bus_full = 1'b1; mif.data_in_BUS = 32'h5555_AAAA;
        rst = 1'b1;
        tick();
        rst = 1'b0; mif.bus_full = 1'b0; mif.dmem_read = 1'b0;
        check("abort_valid", mif.dmem_valid, 1'b0);
        check("abort_rdata", mif.dmem_rdata, 32'h0);
        check("abort_state", state_dbg, 3'd0);
        tick();
        check("abort_no_valid", dv_cnt, 0);

        // Load that never sees bus_full.
        clr_counts();
        mif.dmem_read = 1'b1; mif.dmem_addr = 32'h0000_0030;
`ifdef MEM_REQ_TIMEOUT_EN
        repeat (TIMEOUT_CYCLES + 1) tick();
        mif.dmem_read = 1'b0;
        check("to_err",       mif.timeout_err, 1'b1);
        check("to_valid",     mif.dmem_valid, 1'b1);
        check("to_rdata",     mif.dmem_rdata, 32'hBAD0_0BAD);
        check("to_rd_cycles", rd_hi, 16);
        tick(); tick();
        check("to_err_cnt",   te_cnt, 1);
        // bus_full on the limit edge wins: normal completion.
        clr_counts();
        mif.dmem_read = 1'b1; mif.dmem_addr = 32'h0000_0034;
        serve(TIMEOUT_CYCLES - 1, 32'h0BAD_F00D);
        mif.dmem_read = 1'b0;
        check("limit_no_err", mif.timeout_err, 1'b0);
        check("limit_rdata",  mif.dmem_rdata, 32'h0BAD_F00D);
        tick(); tick();
`else
        repeat (110) tick();
        check("nto_rd_cycles", rd_hi, 109);
        check("nto_err_cnt",   te_cnt, 0);
        check("nto_no_valid",  dv_cnt, 0);
        serve(0, 32'h0000_0077);
        mif.dmem_read = 1'b0;
        tick(); tick();
        check("nto_rdata", mif.dmem_rdata, 32'h0000_0077);
`endif

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
